// File: rtl/bnn_inference_scheduler.sv
// bnn_inference_scheduler
//
// Top-level sequencer for the bit-serial MNIST BNN pipeline. It walks the
// phases pixel/weight load -> layer one -> layer two -> final layer. It
// publishes the registered 3-bit phase code that the register file and
// layer blocks decode.
//
// It also provides:
//   - start/abort control,
//   - a per-phase watchdog on the three compute phases,
//   - result latching with a valid/ack handshake,
//   - a wrapping count of completed inferences.
//
// Result handshake: result_valid rises in the cycle the FSM enters DONE,
// with answer updated in the same cycle. It stays high until the consumer
// holds result_ack=1 in some cycle; result_valid is then low from the next
// cycle. An ack while result_valid=0 has no effect. Entering LOAD for a new
// inference also drops result_valid. answer itself is held until the next
// DONE.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         level, launches load+inference from IDLE
//   abort         level, forces IDLE from any other state
//   load_done     serial load of pixels/weights finished
//   layer_1_done  layer one finished
//   layer_2_done  layer two finished
//   layer_3_done  final layer finished
//   answer_in     final-layer class index, sampled with layer_3_done
//   result_ack    consumer accepts the latched result
//   err_clear     leave the ERR state
//   state         registered phase code:
//                 0 IDLE, 1 LOAD, 2 L1, 3 L2, 4 L3, 5 DONE, 6 ERR
//   busy          high in LOAD/L1/L2/L3
//   result_valid  latched answer is valid
//   answer        latched class index
//   err           high in ERR
//   err_phase     compute phase that timed out (1..3), 0 when none
//   inf_count     completed inferences, wraps
module bnn_inference_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13,
    parameter int INF_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 load_done,
    input  logic                 layer_1_done,
    input  logic                 layer_2_done,
    input  logic                 layer_3_done,
    input  logic [3:0]           answer_in,
    input  logic                 result_ack,
    input  logic                 err_clear,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 result_valid,
    output logic [3:0]           answer,
    output logic                 err,
    output logic [1:0]           err_phase,
    output logic [INF_CNT_W-1:0] inf_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_L1   = 3'd2,
        S_L2   = 3'd3,
        S_L3   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CNT_W-1:0] wd_q;
    logic           timeout;
    logic           compute;
    logic [1:0]     phase_idx;
    logic           state_change;

    // The watchdog counts from 0 on phase entry, so the compare value is
    // reached in the TIMEOUT_CYCLES-th cycle spent in the phase.
    assign timeout      = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign compute      = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_L3);
    assign state_change = (state_d != state_q);

    always_comb begin
        phase_idx = 2'd0;
        case (state_q)
            S_L1:    phase_idx = 2'd1;
            S_L2:    phase_idx = 2'd2;
            S_L3:    phase_idx = 2'd3;
            default: phase_idx = 2'd0;
        endcase
    end

    // Next-state logic. Within a compute phase the matching done strobe is
    // checked before the timeout, so a done in the final cycle still
    // advances. abort is applied last and overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !abort) state_d = S_LOAD;
            S_LOAD: if (load_done)       state_d = S_L1;
            S_L1: begin
                if (layer_1_done)        state_d = S_L2;
                else if (timeout)        state_d = S_ERR;
            end
            S_L2: begin
                if (layer_2_done)        state_d = S_L3;
                else if (timeout)        state_d = S_ERR;
            end
            S_L3: begin
                if (layer_3_done)        state_d = S_DONE;
                else if (timeout)        state_d = S_ERR;
            end
            S_DONE:                      state_d = S_IDLE;
            S_ERR:  if (err_clear)       state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Watchdog: zeroed on every state change, counts only in compute phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_change) begin
            wd_q <= '0;
        end else if (compute) begin
            wd_q <= wd_q + CNT_W'(1);
        end
    end

    // err_phase records which compute phase timed out. It is cleared on any
    // exit from ERR, whether by err_clear or by abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_phase <= 2'd0;
        end else if ((state_d == S_ERR) && (state_q != S_ERR)) begin
            err_phase <= phase_idx;
        end else if ((state_q == S_ERR) && (state_d != S_ERR)) begin
            err_phase <= 2'd0;
        end
    end

    // Result latch and inference counter. A new result takes precedence
    // over a same-cycle ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            answer       <= 4'd0;
            inf_count    <= '0;
        end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            result_valid <= 1'b1;
            answer       <= answer_in;
            inf_count    <= inf_count + INF_CNT_W'(1);
        end else if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            result_valid <= 1'b0;
        end else if (result_ack) begin
            result_valid <= 1'b0;
        end
    end

    assign state = state_q;
    assign busy  = (state_q == S_LOAD) || compute;
    assign err   = (state_q == S_ERR);

endmodule
